// File: rtl/zint_pkg.sv
// Shared definitions for the Z80 IM2 interrupt-acknowledge block:
// FSM state encoding, LATCH dwell length, vector reset value and RETI opcodes.
package zint_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } zint_state_t;

  // Number of clk cycles spent in LATCH before the vector is captured.
  localparam int unsigned LATCH_LEN = 3;

  // Last counter value in LATCH; the vector is captured on this count.
  localparam logic [1:0] LATCH_LAST = 2'(LATCH_LEN - 1);

  localparam logic [7:0] VECT_RST = 8'hFF;
  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_4D    = 8'h4D;

endpackage

// File: rtl/zreti_dec.sv
// RETI decoder: watches Z80 opcode fetches and pulses reti_stb for one clk
// two clks after the 4D byte of an ED 4D pair. An acknowledge cycle between
// the two bytes cancels the pending ED.
module zreti_dec
  import zint_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic [7:0] di,
  input  logic       ack,
  output logic       reti_stb
);

  logic fetch;
  logic sample;
  logic fetch_q;
  logic ed_flag;
  logic hit_q;

  assign fetch  = !m1_n && !mreq_n && !rd_n;
  // The fetched byte is taken on the clk where /RD is first seen high again.
  assign sample = fetch_q && rd_n;

  // Track fetch phase, remember a preceding ED and emit the delayed RETI pulse.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      fetch_q  <= 1'b0;
      ed_flag  <= 1'b0;
      hit_q    <= 1'b0;
      reti_stb <= 1'b0;
    end else begin
      fetch_q <= fetch;
      if (ack) begin
        ed_flag <= 1'b0;
      end else if (sample) begin
        ed_flag <= (di == OP_ED);
      end
      hit_q    <= sample && !ack && ed_flag && (di == OP_4D);
      reti_stb <= hit_q;
    end
  end

endmodule

// File: rtl/zintack.sv
// Z80 IM2 interrupt acknowledge sequencer. Detects the M1+IORQ acknowledge
// cycle, waits for the interrupt controller to settle its vector, latches it
// and drives it onto the CPU data bus until the cycle ends.
// Optional RETI decoding is enabled by defining ZINTACK_RETI_EN.
module zintack
  import zint_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       zpos,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic [7:0] di,
  input  logic       int_n,
  input  logic [7:0] im2vect,
  output logic       intack,
  output logic       vect_oe,
  output logic [7:0] vect_do,
  output logic       reti_stb
);

  zint_state_t state;
  zint_state_t state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic [7:0]  vect_nxt;
  logic        bus_low;
  logic        bus_high;

  assign bus_low  = !m1_n && !iorq_n;
  assign bus_high = m1_n && iorq_n;

  // State, LATCH counter and captured vector registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      vect_do <= VECT_RST;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vect_do <= vect_nxt;
    end
  end

  // Next-state logic: the acknowledge request level is ignored on purpose,
  // since the CPU alone decides when to run an acknowledge cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vect_nxt  = vect_do;
    case (state)
      IDLE: begin
        if (zpos && bus_low) begin
          state_nxt = LATCH;
          cnt_nxt   = 2'd0;
        end
      end
      LATCH: begin
        if (!bus_low) begin
          state_nxt = RELEASE;
          cnt_nxt   = 2'd0;
        end else if (cnt == LATCH_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = 2'd0;
          vect_nxt  = im2vect;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      DRIVE: begin
        if (!bus_low) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (bus_high) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  assign intack  = (state != IDLE);
  assign vect_oe = (state == DRIVE) && bus_low;

`ifdef ZINTACK_RETI_EN
  zreti_dec u_reti (
    .clk      (clk),
    .res      (res),
    .m1_n     (m1_n),
    .mreq_n   (mreq_n),
    .rd_n     (rd_n),
    .di       (di),
    .ack      (intack),
    .reti_stb (reti_stb)
  );

  logic unused_inputs;
  assign unused_inputs = int_n;
`else
  assign reti_stb = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{int_n, mreq_n, rd_n, di};
`endif

endmodule

// File: tb/tb_zintack.sv
// Directed self-checking bench for zintack: reset values, abort in LATCH,
// normal IM2 acknowledge, back-to-back acknowledges, reset during DRIVE and
// RETI decoding (expected pulse only when ZINTACK_RETI_EN is defined).
module tb_zintack;

  logic       clk;
  logic       res;
  logic       zpos;
  logic       m1_n;
  logic       iorq_n;
  logic       mreq_n;
  logic       rd_n;
  logic [7:0] di;
  logic       int_n;
  logic [7:0] im2vect;
  logic       intack;
  logic       vect_oe;
  logic [7:0] vect_do;
  logic       reti_stb;

  int compared;
  int mismatched;
  int pulses;

`ifdef ZINTACK_RETI_EN
  localparam logic EXP_RETI = 1'b1;
`else
  localparam logic EXP_RETI = 1'b0;
`endif

  zintack dut (
    .clk      (clk),
    .res      (res),
    .zpos     (zpos),
    .m1_n     (m1_n),
    .iorq_n   (iorq_n),
    .mreq_n   (mreq_n),
    .rd_n     (rd_n),
    .di       (di),
    .int_n    (int_n),
    .im2vect  (im2vect),
    .intack   (intack),
    .vect_oe  (vect_oe),
    .vect_do  (vect_do),
    .reti_stb (reti_stb)
  );

  // Free-running 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic zp, input logic m1, input logic iorq,
                               input logic mreq, input logic rd);
    zpos   = zp;
    m1_n   = m1;
    iorq_n = iorq;
    mreq_n = mreq;
    rd_n   = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One opcode fetch; returns on the clk where /RD has just been seen high.
  task automatic doFetch(input logic [7:0] b);
    di = b;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
  endtask

  task automatic startAck(input logic [7:0] vec);
    im2vect = vec;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    zpos = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    res        = 1'b1;
    di         = 8'h00;
    int_n      = 1'b1;
    im2vect    = 8'h00;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset values
    tick();
    checkOutput("rst_intack", {7'd0, intack}, 8'h00);
    checkOutput("rst_vect_oe", {7'd0, vect_oe}, 8'h00);
    checkOutput("rst_vect_do", vect_do, 8'hFF);
    checkOutput("rst_reti", {7'd0, reti_stb}, 8'h00);
    tick();
    res = 1'b0;

    // Bus low without zpos never starts an acknowledge
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    checkOutput("nozpos_intack", {7'd0, intack}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();

    // Abort: IORQ rises two clks into LATCH
    startAck(8'hA5);
    checkOutput("abort_intack_rise", {7'd0, intack}, 8'h01);
    tick();
    iorq_n = 1'b1;
    checkOutput("abort_oe_a", {7'd0, vect_oe}, 8'h00);
    tick();
    checkOutput("abort_intack_rel", {7'd0, intack}, 8'h01);
    checkOutput("abort_vect_keep", vect_do, 8'hFF);
    checkOutput("abort_oe_b", {7'd0, vect_oe}, 8'h00);
    tick();
    checkOutput("abort_hold_rel", {7'd0, intack}, 8'h01);
    m1_n = 1'b1;
    tick();
    checkOutput("abort_idle", {7'd0, intack}, 8'h00);
    checkOutput("abort_vect_final", vect_do, 8'hFF);

    // Normal acknowledge with vector FD
    int_n = 1'b0;
    startAck(8'hFD);
    checkOutput("ack_intack_p1", {7'd0, intack}, 8'h01);
    checkOutput("ack_vect_p1", vect_do, 8'hFF);
    tick(); tick();
    checkOutput("ack_vect_p3", vect_do, 8'hFF);
    checkOutput("ack_oe_p3", {7'd0, vect_oe}, 8'h00);
    tick();
    checkOutput("ack_vect_p4", vect_do, 8'hFD);
    checkOutput("ack_oe_p4", {7'd0, vect_oe}, 8'h01);
    tick();
    checkOutput("ack_oe_p5", {7'd0, vect_oe}, 8'h01);
    iorq_n = 1'b1;
    #1;
    checkOutput("ack_oe_iorq_hi", {7'd0, vect_oe}, 8'h00);
    checkOutput("ack_intack_iorq_hi", {7'd0, intack}, 8'h01);
    tick();
    checkOutput("ack_release", {7'd0, intack}, 8'h01);
    m1_n = 1'b1;
    tick();
    checkOutput("ack_idle", {7'd0, intack}, 8'h00);
    checkOutput("ack_vect_hold", vect_do, 8'hFD);
    int_n = 1'b1;

    // Back-to-back acknowledges: FF then FB
    startAck(8'hFF);
    tick(); tick(); tick();
    checkOutput("b2b_vect_ff", vect_do, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("b2b_release", {7'd0, intack}, 8'h01);
    tick();
    checkOutput("b2b_gap", {7'd0, intack}, 8'h00);
    startAck(8'hFB);
    checkOutput("b2b_intack2", {7'd0, intack}, 8'h01);
    tick(); tick(); tick();
    checkOutput("b2b_vect_fb", vect_do, 8'hFB);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    checkOutput("b2b_end_idle", {7'd0, intack}, 8'h00);
    checkOutput("b2b_end_vect", vect_do, 8'hFB);

    // Reset pulse during DRIVE with the bus still low
    startAck(8'h77);
    tick(); tick(); tick();
    checkOutput("rstd_vect", vect_do, 8'h77);
    checkOutput("rstd_oe", {7'd0, vect_oe}, 8'h01);
    res = 1'b1;
    #1;
    checkOutput("rstd_intack_now", {7'd0, intack}, 8'h00);
    checkOutput("rstd_oe_now", {7'd0, vect_oe}, 8'h00);
    checkOutput("rstd_vect_now", vect_do, 8'hFF);
    tick();
    res = 1'b0;
    tick(); tick();
    checkOutput("rstd_no_reentry", {7'd0, intack}, 8'h00);
    checkOutput("rstd_no_oe", {7'd0, vect_oe}, 8'h00);
    zpos = 1'b1;
    tick();
    zpos = 1'b0;
    checkOutput("rstd_reentry", {7'd0, intack}, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    checkOutput("rstd_final_idle", {7'd0, intack}, 8'h00);
    checkOutput("rstd_final_vect", vect_do, 8'hFF);

    // RETI: ED,4D gives a single pulse two clks after the 4D fetch
    doFetch(8'hED);
    tick();
    doFetch(8'h4D);
    checkOutput("reti_p0", {7'd0, reti_stb}, 8'h00);
    tick();
    checkOutput("reti_p1", {7'd0, reti_stb}, {7'd0, EXP_RETI});
    tick();
    checkOutput("reti_p2", {7'd0, reti_stb}, 8'h00);

    // RETI: ED,00,4D gives no pulse
    doFetch(8'hED);
    doFetch(8'h00);
    doFetch(8'h4D);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(reti_stb);
    end
    checkOutput("reti_ed00_4d", 8'(pulses), 8'h00);

    // RETI: ED, acknowledge, 4D gives no pulse
    doFetch(8'hED);
    startAck(8'h12);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    checkOutput("reti_ack_idle", {7'd0, intack}, 8'h00);
    doFetch(8'h4D);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(reti_stb);
    end
    checkOutput("reti_ed_ack_4d", 8'(pulses), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/zintack.md
ZINTACK -- requirements
Module: zintack

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 res  in  1  reset, asynchronous, active-high.
REQ-003 zpos  in  1  Z80 clock positive-phase strobe, one clk wide.
REQ-004 m1_n  in  1  Z80 /M1, already in clk domain.
REQ-005 iorq_n  in  1  Z80 /IORQ, already in clk domain.
REQ-006 mreq_n  in  1  Z80 /MREQ, already in clk domain.
REQ-007 rd_n  in  1  Z80 /RD, already in clk domain.
REQ-008 di  in  8  CPU data-in bus (opcode fetch data).
REQ-009 int_n  in  1  interrupt request from the interrupt controller, active-low.
REQ-010 im2vect  in  8  IM2 vector from the interrupt controller.
REQ-011 intack  out  1  acknowledge level to the interrupt controller.
REQ-012 vect_oe  out  1  vector drive enable onto CPU data bus.
REQ-013 vect_do  out  8  latched vector to drive.
REQ-014 reti_stb  out  1  one-clk pulse on decoded RETI (only with ZINTACK_RETI_EN).

Function
REQ-015 The FSM SHALL have states IDLE, LATCH, DRIVE, RELEASE, encoded 2 bits.
REQ-016 IDLE->LATCH SHALL occur on a clk with zpos=1, m1_n=0, iorq_n=0 (ack cycle start).
REQ-017 intack SHALL be 1 in LATCH, DRIVE and RELEASE, 0 in IDLE (registered; rises 1 clk after detect).
REQ-018 LATCH SHALL last exactly 3 clks (2-bit counter), covering the controller's edge detect plus vector register delay.
REQ-019 On LATCH exit vect_do SHALL capture im2vect and the FSM SHALL enter DRIVE.
REQ-020 vect_oe SHALL be 1 only in DRIVE and only while m1_n=0 and iorq_n=0 (combinational gate of registered state).
REQ-021 DRIVE->RELEASE SHALL occur on the first clk with iorq_n=1 or m1_n=1.
REQ-022 RELEASE->IDLE SHALL occur on the first clk with m1_n=1 and iorq_n=1 both; a new ack cannot start before IDLE.
REQ-023 If m1_n or iorq_n goes high during LATCH, the FSM SHALL go to RELEASE without capturing vect_do (abort; vect_oe never asserts).
REQ-024 int_n SHALL NOT gate ack entry (CPU decides); an ack with int_n=1 SHALL proceed and drive whatever im2vect holds.
REQ-025 vect_do SHALL hold its value between acks.

Reset
REQ-026 On res=1 (async): state=IDLE, counter=0, intack=0, vect_do=8'hFF, reti_stb=0, RETI decoder cleared.
REQ-027 res asserted mid-ack SHALL drop intack and vect_oe immediately; after release an ack in progress (m1_n, iorq_n still low) SHALL NOT be re-detected until a new zpos with both low.

Configuration
REQ-028 With ZINTACK_RETI_EN defined: opcode fetch (m1_n=0, mreq_n=0, rd_n=0) data SHALL be sampled on the clk where rd_n rises; ED followed by 4D on the next fetch SHALL pulse reti_stb for 1 clk, 2 clks after the 4D fetch ends; any other byte, or an intervening ack, clears the ED flag.
REQ-029 Without ZINTACK_RETI_EN: reti_stb SHALL be tied 0 and decoder flops SHALL not exist; mreq_n, rd_n, di unused.

Structure
REQ-030 Shared package zint_pkg SHALL hold the state enum, LATCH length constant (3), reset vector 8'hFF and opcodes 8'hED, 8'h4D.
REQ-031 RETI decoder SHALL be a sub-module zreti_dec, instantiated only under ZINTACK_RETI_EN.

Verification
REQ-032 im2vect=8'hFD, ack with zpos: intack at +1 clk, vect_do=8'hFD at +4 clk, vect_oe=1 until iorq_n=1.
REQ-033 iorq_n high 2 clks into LATCH: vect_do keeps 8'hFF, vect_oe never 1, IDLE after m1_n=1.
REQ-034 res pulse during DRIVE with bus still low: intack=0 at once, no re-entry until next zpos with both low.
REQ-035 Fetches ED,4D (RETI_EN): one reti_stb pulse; ED,00,4D: none; ED, ack, 4D: none.
REQ-036 Back-to-back acks im2vect 8'hFF then 8'hFB: vect_do 8'hFF then 8'hFB, intack falls between them.
